// File: rtl/result_collector_pkg.sv
// result_collector_pkg: shared defaults and types for the result collector slice
package result_collector_pkg;
  localparam int N_UNITS_DEF = 8;
  localparam int N_UNITSBITS_DEF = 3;
  localparam int PROB_W_DEF = 8;
  localparam int RES_W_DEF = 32;
  localparam int DEPTH_DEF = 4;
  typedef logic [1:0] state_t;
endpackage

// File: rtl/result_collector_if.sv
// result_collector_if: work-unit done/ack bus plus main-control valid/ready drain
interface result_collector_if
  import result_collector_pkg::*;
#(
  parameter int N_UNITS = N_UNITS_DEF,
  parameter int PROB_W = PROB_W_DEF,
  parameter int RES_W = RES_W_DEF
);
  logic [N_UNITS-1:0] i_wu_done;
  logic [N_UNITS*PROB_W-1:0] i_wu_prob_no;
  logic [N_UNITS*RES_W-1:0] i_wu_result;
  logic [N_UNITS-1:0] o_wu_ack;
  logic o_mc_valid;
  logic [PROB_W-1:0] o_mc_prob_no;
  logic [RES_W-1:0] o_mc_result;
  logic i_mc_ready;
  logic o_busy;
  modport slave (
    input i_wu_done, i_wu_prob_no, i_wu_result, i_mc_ready,
    output o_wu_ack, o_mc_valid, o_mc_prob_no, o_mc_result, o_busy
  );
  modport master (
    output i_wu_done, i_wu_prob_no, i_wu_result, i_mc_ready,
    input o_wu_ack, o_mc_valid, o_mc_prob_no, o_mc_result, o_busy
  );
endinterface

// File: rtl/result_collector_rr_pick.sv
// rr_pick: round-robin pick; rotate requests by ptr, take lowest set bit, un-rotate
module rr_pick #(
  parameter int N = 8,
  parameter int NB = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [NB-1:0] ptr_i,
  output logic [NB-1:0] g_o,
  output logic          found_o
);
  logic [N-1:0] rot;
  logic [NB-1:0] idx;
  always_comb begin
    rot = '0;
    idx = '0;
    for (int i = 0; i < N; i++) rot[i] = req_i[NB'(ptr_i + NB'(i))];
    for (int i = N - 1; i >= 0; i--) if (rot[i]) idx = NB'(i);
  end
  assign g_o = ptr_i + idx;
  assign found_o = |req_i;
endmodule

// File: rtl/result_collector.sv
// result_collector: round-robin result arbiter feeding a show-ahead FIFO to main control
module result_collector
  import result_collector_pkg::*;
#(
  parameter int N_UNITS = N_UNITS_DEF,
  parameter int N_UNITSBITS = N_UNITSBITS_DEF,
  parameter int PROB_W = PROB_W_DEF,
  parameter int RES_W = RES_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic i_clk300,
  input logic i_reset,
  result_collector_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_CAPTURE = 2'd1, S_HOLD = 2'd2;
  localparam int DB = $clog2(DEPTH);
  state_t state_q, state_d;
  logic [N_UNITSBITS-1:0] rr_q, g_q, g;
  logic found, grant, push, pop;
  logic [DB-1:0] wr_q, rd_q;
  logic [DB:0] count_q;
  logic [PROB_W-1:0] prob_mem [DEPTH];
  logic [RES_W-1:0] res_mem [DEPTH];
  rr_pick #(.N(N_UNITS), .NB(N_UNITSBITS)) u_pick (
    .req_i(bus.i_wu_done), .ptr_i(rr_q), .g_o(g), .found_o(found)
  );
  // a full FIFO holds off the grant, so the requester keeps done high until space frees
  assign grant = state_q == S_IDLE && found && count_q < (DB+1)'(DEPTH);
  assign push = state_q == S_CAPTURE;
  assign pop = bus.o_mc_valid && bus.i_mc_ready;
  always_comb state_d = grant ? S_CAPTURE : state_q == S_CAPTURE ? S_HOLD : S_IDLE;
  always_ff @(posedge i_clk300 or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      rr_q <= '0;
      g_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) g_q <= g;
      if (push) rr_q <= g_q + 1'b1;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + (DB+1)'(push) - (DB+1)'(pop);
    end
  end
  always_ff @(posedge i_clk300) begin
    if (push) prob_mem[wr_q] <= bus.i_wu_prob_no[g_q*PROB_W +: PROB_W];
    if (push) res_mem[wr_q] <= bus.i_wu_result[g_q*RES_W +: RES_W];
  end
  assign bus.o_wu_ack = push ? N_UNITS'(1) << g_q : '0;
  assign bus.o_mc_valid = count_q != '0;
  assign bus.o_mc_prob_no = prob_mem[rd_q];
  assign bus.o_mc_result = res_mem[rd_q];
  assign bus.o_busy = state_q != S_IDLE || count_q != '0 || |bus.i_wu_done;
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: random unit traffic against a queue-based model of arbitration and FIFO order
module tb_result_collector;
  localparam int N = 8, PW = 8, RW = 32, D = 4;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  result_collector_if #(.N_UNITS(N), .PROB_W(PW), .RES_W(RW)) bus ();
  result_collector #(.N_UNITS(N), .N_UNITSBITS(3), .PROB_W(PW), .RES_W(RW), .DEPTH(D)) dut (
    .i_clk300(clk), .i_reset(rst), .bus(bus)
  );
  int checks = 0, errors = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [N-1:0] done;
  logic [PW-1:0] prob [N];
  logic [RW-1:0] res [N];
  logic ready;
  assign bus.i_wu_done = done;
  assign bus.i_mc_ready = ready;
  always_comb begin
    bus.i_wu_prob_no = '0;
    bus.i_wu_result = '0;
    for (int u = 0; u < N; u++) begin
      bus.i_wu_prob_no[u*PW +: PW] = prob[u];
      bus.i_wu_result[u*RW +: RW] = res[u];
    end
  end
  logic [PW+RW-1:0] q[$];
  logic [PW+RW-1:0] ack_entry;
  int pend, gnt, rr, drop_u, n_acks;
  bit ack_prev, pop_prev;
  task automatic model_clear();
    q.delete();
    pend = 0;
    rr = 0;
    ack_prev = 0;
    pop_prev = 0;
    drop_u = -1;
  endtask
  task automatic cycle(logic [N-1:0] mask, int req_pct, int rdy_pct, bit fixed);
    @(posedge clk);
    if (ack_prev) q.push_back(ack_entry);
    if (pop_prev) q.delete(0);
    ack_prev = 0;
    pop_prev = 0;
    #1;
    for (int u = 0; u < N; u++) begin
      if (drop_u == u) done[u] = 0;
      else if (!done[u] && mask[u] && $urandom_range(99) < req_pct) begin
        done[u] = 1;
        prob[u] = fixed ? 8'd7 : PW'($urandom);
        res[u] = fixed ? 32'hDEADBEEF : $urandom;
      end
    end
    drop_u = -1;
    ready = $urandom_range(99) < rdy_pct;
    #1;
    chk("ack", bus.o_wu_ack, pend == 2 ? N'(1) << gnt : '0);
    chk("valid", bus.o_mc_valid, q.size() != 0);
    if (q.size() != 0) chk("head", {bus.o_mc_prob_no, bus.o_mc_result}, q[0]);
    chk("busy", bus.o_busy, pend != 0 || q.size() != 0 || |done);
    if (pend == 2) begin
      ack_prev = 1;
      ack_entry = {prob[gnt], res[gnt]};
      drop_u = gnt;
      rr = (gnt + 1) % N;
      n_acks++;
    end
    pop_prev = q.size() != 0 && ready;
    if (pend > 0) pend--;
    else if (|done && q.size() < D) begin
      for (int k = N - 1; k >= 0; k--) if (done[(rr + k) % N]) gnt = (rr + k) % N;
      pend = 2;
    end
  endtask
  task automatic reset_all();
    @(posedge clk);
    #1;
    rst = 1;
    done = '0;
    #1;
    chk("rst_ack", bus.o_wu_ack, 0);
    chk("rst_valid", bus.o_mc_valid, 0);
    @(posedge clk);
    #1;
    rst = 0;
    model_clear();
  endtask
  task automatic reset_mid();
    int k = 0;
    while (!(pend == 2 && !pop_prev && q.size() + int'(ack_prev) == 3) && k < 200) begin
      cycle(8'hFF, 100, 0, 0);
      k++;
    end
    chk("mid_reach", k < 200, 1);
    @(posedge clk);
    #1;
    chk("mid_ack_before", bus.o_wu_ack, N'(1) << gnt);
    chk("mid_valid_before", bus.o_mc_valid, 1);
    rst = 1;
    done = '0;
    #1;
    chk("mid_ack_after", bus.o_wu_ack, 0);
    chk("mid_valid_after", bus.o_mc_valid, 0);
    chk("mid_busy_after", bus.o_busy, 0);
    @(posedge clk);
    #1;
    rst = 0;
    model_clear();
  endtask
  initial begin
    done = '0;
    ready = 0;
    n_acks = 0;
    for (int u = 0; u < N; u++) begin
      prob[u] = '0;
      res[u] = '0;
    end
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", bus.o_wu_ack, 0);
    chk("rst_valid", bus.o_mc_valid, 0);
    chk("rst_busy_idle", bus.o_busy, 0);
    done = 8'h04;
    #1;
    chk("rst_busy_req", bus.o_busy, 1);
    done = '0;
    @(posedge clk);
    #1;
    rst = 0;
    repeat (12) cycle(8'h20, 100, 100, 1);
    reset_all();
    repeat (30) cycle(8'hFF, 100, 100, 0);
    reset_all();
    repeat (40) cycle(8'h03, 60, 50, 0);
    repeat (300) cycle(8'hFF, 40, 10, 0);
    repeat (600) cycle(8'hFF, 30, 70, 0);
    reset_mid();
    repeat (100) cycle(8'hFF, 50, 60, 0);
    chk("acks_seen", n_acks > 50, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
